spi_slave_mode: RTL and testbench
=================================

SPI_SLAVE_MODE -- requirements
Module: spi_slave_mode

Interface
REQ-001 Parameter reg_width, default 8: max transfer length and data width in bits (>=2).
REQ-002 Parameter counter_width, default $clog2(reg_width): bit-counter width; counters and t_size_s are counter_width+1 bits.
REQ-003 slave_clk  in  1  single system clock; all logic rising-edge on it.
REQ-004 rstn  in  1  reset, asynchronous assert, active-low.
REQ-005 spi_clk  in  1  external SPI clock, asynchronous to slave_clk.
REQ-006 cs_n  in  1  chip select, active-low, asynchronous.
REQ-007 mosi  in  1  serial data from master, asynchronous.
REQ-008 miso  out  1  serial data to master.
REQ-009 t_start  in  1  one-cycle request: load d_in_s as next transmit word.
REQ-010 d_in_s  in  reg_width  transmit word.
REQ-011 t_size_s  in  counter_width+1  bits per transfer; sampled with t_start.
REQ-012 cpol, cpha  in  1 each  SPI mode; sampled with t_start.
REQ-013 lsb_first  in  1  bit order; sampled with t_start.
REQ-014 d_out_s  out  reg_width  last completed receive word, right-aligned.
REQ-015 busy  out  1  high in LOAD, TRANSACT, UNLOAD.
REQ-016 done  out  1  one-cycle pulse on completed transfer.
REQ-017 err  out  1  one-cycle pulse on abort or ignored t_start.

Function
REQ-018 spi_clk, cs_n, mosi SHALL pass through 2-flop synchronizers before use; edges detected on synchronized values.
REQ-019 States RESET, IDLE, LOAD, TRANSACT, UNLOAD; RESET->IDLE on first cycle after rstn deasserts.
REQ-020 IDLE + t_start -> LOAD: latch d_in_s, t_size_s, cpol, cpha, lsb_first; effective size = t_size_s, clamped to reg_width if 0 or >reg_width.
REQ-021 LOAD (1 cycle): present first transmit bit on miso; -> TRANSACT when synchronized cs_n low, else stay in LOAD.
REQ-022 cs_n falling in IDLE without prior t_start: transfer proceeds with all-zero transmit word and last latched mode/size (reset mode 0, size reg_width).
REQ-023 Leading edge = spi_clk leaving cpol level; sample edge = leading if cpha=0, trailing if cpha=1; other edge is shift edge.
REQ-024 On sample edge: shift synchronized mosi into receive register, increment bit counter.
REQ-025 On shift edge: drive next transmit bit on miso; with cpha=1 first bit driven on first leading edge instead of in LOAD.
REQ-026 lsb_first=0 transmits bit size-1 down to 0; lsb_first=1 transmits bit 0 up to size-1; receive order mirrors.
REQ-027 Counter reaching effective size -> UNLOAD: d_out_s <= received bits right-aligned, upper bits zero; done=1 one cycle; -> IDLE next cycle.
REQ-028 cs_n rising in LOAD or TRANSACT before completion: abort -> IDLE, err=1 one cycle, d_out_s unchanged, no done.
REQ-029 t_start while busy: ignored, err=1 one cycle, latched settings unchanged.
REQ-030 miso SHALL be 0 whenever synchronized cs_n high or state IDLE.
REQ-031 Correct operation guaranteed for spi_clk half-period >= 4 slave_clk cycles.

Reset
REQ-032 rstn low asynchronously: state RESET, d_out_s=0, miso=0, busy=0, done=0, err=0, counter=0, synchronizers to idle (spi_clk 0, cs_n 1, mosi 0).
REQ-033 Reset mid-transfer discards partial data; no done or err pulse.

Structure
REQ-034 Shared package spi_pkg SHALL hold state encoding (RESET..UNLOAD) and mode constants (MODE0..MODE3).
REQ-035 One sub-module spi_sync_edge: 2-flop synchronizer with rise/fall pulse outputs, instantiated for spi_clk and cs_n; mosi uses synchronizer only.

Verification
REQ-036 Mode 0, size 8, MSB-first, d_in_s=8'h55, master sends 8'hA3 -> miso stream 01010101, d_out_s=8'hA3, one done pulse.
REQ-037 Mode 3, size 8, LSB-first, d_in_s=8'hAA, master sends 8'h0F LSB-first -> miso 0,1,0,1,0,1,0,1, d_out_s=8'h0F.
REQ-038 Mode 1, t_size_s=5, d_in_s=8'h13, master sends 5'b10110 -> miso 10011, d_out_s=8'h16.
REQ-039 cs_n raised after 3 bits -> err pulse, d_out_s retains prior value, state IDLE, no done.
REQ-040 t_start during TRANSACT with d_in_s=8'hFF -> err pulse, current transfer completes with original data.
REQ-041 rstn low mid-transfer then high -> all outputs reset values, next full transfer (t_size_s=0 -> 8 bits) completes correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and SPI mode constants for the SPI slave
package spi_pkg;

  typedef enum logic [2:0] {
    RESET    = 3'd0,
    IDLE     = 3'd1,
    LOAD     = 3'd2,
    TRANSACT = 3'd3,
    UNLOAD   = 3'd4
  } spi_state_t;

  // Mode number encodes {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - 2-flop synchronizer with rise/fall pulses on the synchronized value
module spi_sync_edge #(
  parameter logic reset_val = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= reset_val;
      sync <= reset_val;
      prev <= reset_val;
    end else begin
      meta <= d;
      sync <= meta;
      prev <= sync;
    end
  end

  assign q    = sync;
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_slave_mode.sv
// rtl/spi_slave_mode.sv - SPI slave, all four modes, programmable length and bit order
module spi_slave_mode
  import spi_pkg::*;
#(
  parameter int reg_width     = 8,
  parameter int counter_width = $clog2(reg_width)
) (
  input  logic                     slave_clk,
  input  logic                     rstn,
  input  logic                     spi_clk,
  input  logic                     cs_n,
  input  logic                     mosi,
  output logic                     miso,
  input  logic                     t_start,
  input  logic [reg_width-1:0]     d_in_s,
  input  logic [counter_width:0]   t_size_s,
  input  logic                     cpol,
  input  logic                     cpha,
  input  logic                     lsb_first,
  output logic [reg_width-1:0]     d_out_s,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int cw1 = counter_width + 1;
  localparam logic [counter_width:0] full_size = cw1'(reg_width);

  spi_state_t state, state_nxt;

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_meta, mosi_s;

  logic [reg_width-1:0]   tx_word;
  logic [reg_width-1:0]   rx_sr;
  logic [counter_width:0] size_q;
  logic [1:0]             mode_q;
  logic                   lsb_q;
  logic [counter_width:0] rx_cnt;
  logic [counter_width:0] tx_cnt;
  logic                   miso_q;

  logic sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  logic [counter_width:0] rx_cnt_inc, tx_pos, tx_idx, size_eff;
  logic tx_bit, last_bit, latch_req, auto_req, abort, ignored_start;

  spi_sync_edge #(.reset_val(1'b0)) u_sync_sclk (
    .clk (slave_clk), .rstn(rstn), .d(spi_clk),
    .q   (sclk_s),    .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.reset_val(1'b1)) u_sync_cs (
    .clk (slave_clk), .rstn(rstn), .d(cs_n),
    .q   (cs_s),      .rise(cs_rise), .fall(cs_fall)
  );

  // Leading edge moves spi_clk away from its idle (cpol) level
  assign sclk_edge   = sclk_rise | sclk_fall;
  assign lead_edge   = sclk_edge & (sclk_s != mode_q[1]);
  assign trail_edge  = sclk_edge & (sclk_s == mode_q[1]);
  assign sample_edge = mode_q[0] ? trail_edge : lead_edge;
  assign shift_edge  = mode_q[0] ? lead_edge  : trail_edge;

  assign rx_cnt_inc = rx_cnt + cw1'(1);
  assign last_bit   = sample_edge && (rx_cnt_inc == size_q);

  // LOAD always presents bit position 0 of the transfer
  assign tx_pos = (state == LOAD) ? '0 : tx_cnt;
  assign tx_idx = lsb_q ? tx_pos : (size_q - cw1'(1) - tx_pos);
  assign tx_bit = |(tx_word & (reg_width'(1) << tx_idx));

  assign size_eff = ((t_size_s == '0) || (t_size_s > full_size)) ? full_size : t_size_s;

  assign busy          = (state == LOAD) || (state == TRANSACT) || (state == UNLOAD);
  assign ignored_start = t_start & busy;
  assign miso          = miso_q & ~cs_s & (state != IDLE);

  always_ff @(posedge slave_clk or negedge rstn) begin
    if (!rstn) state <= RESET;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch_req = 1'b0;
    auto_req  = 1'b0;
    abort     = 1'b0;
    case (state)
      RESET: state_nxt = IDLE;
      IDLE: begin
        if (t_start) begin
          state_nxt = LOAD;
          latch_req = 1'b1;
        end else if (cs_fall) begin
          state_nxt = LOAD;
          auto_req  = 1'b1;
        end
      end
      LOAD: begin
        if (cs_rise) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end else if (!cs_s) begin
          state_nxt = TRANSACT;
        end
      end
      TRANSACT: begin
        if (last_bit) begin
          state_nxt = UNLOAD;
        end else if (cs_rise) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end
      end
      UNLOAD:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge slave_clk or negedge rstn) begin
    if (!rstn) begin
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
      tx_word   <= '0;
      size_q    <= full_size;
      mode_q    <= MODE0;
      lsb_q     <= 1'b0;
      rx_sr     <= '0;
      rx_cnt    <= '0;
      tx_cnt    <= '0;
      miso_q    <= 1'b0;
      d_out_s   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mosi_meta <= mosi;
      mosi_s    <= mosi_meta;
      done      <= (state == UNLOAD);
      err       <= abort | ignored_start;

      if (latch_req) begin
        tx_word <= d_in_s;
        size_q  <= size_eff;
        mode_q  <= {cpol, cpha};
        lsb_q   <= lsb_first;
      end else if (auto_req) begin
        tx_word <= '0;
      end

      if (state == LOAD) begin
        rx_sr  <= '0;
        rx_cnt <= '0;
        // With cpha=1 the first bit waits for the first leading edge
        if (mode_q[0]) begin
          miso_q <= 1'b0;
          tx_cnt <= '0;
        end else begin
          miso_q <= tx_bit;
          tx_cnt <= cw1'(1);
        end
      end else if (state == TRANSACT) begin
        if (sample_edge) begin
          rx_sr  <= lsb_q ? (rx_sr | (reg_width'(mosi_s) << rx_cnt))
                          : {rx_sr[reg_width-2:0], mosi_s};
          rx_cnt <= rx_cnt_inc;
        end
        if (shift_edge && (tx_cnt < size_q)) begin
          miso_q <= tx_bit;
          tx_cnt <= tx_cnt + cw1'(1);
        end
      end

      if (state == UNLOAD) d_out_s <= rx_sr;
    end
  end

endmodule

// File: tb/tb_spi_slave_mode.sv
// tb/tb_spi_slave_mode.sv - self-checking bench for spi_slave_mode
module tb_spi_slave_mode;

  localparam int HALF = 5;

  logic       slave_clk = 1'b0;
  logic       rstn      = 1'b0;
  logic       spi_clk   = 1'b0;
  logic       cs_n      = 1'b1;
  logic       mosi      = 1'b0;
  logic       miso;
  logic       t_start   = 1'b0;
  logic [7:0] d_in_s    = 8'h00;
  logic [3:0] t_size_s  = 4'd0;
  logic       cpol      = 1'b0;
  logic       cpha      = 1'b0;
  logic       lsb_first = 1'b0;
  logic [7:0] d_out_s;
  logic       busy, done, err;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  // Reference model: settings latched by the last accepted t_start
  logic m_cp = 1'b0, m_ch = 1'b0, m_lsb = 1'b0;
  int   m_n  = 8;

  spi_slave_mode #(.reg_width(8), .counter_width(3)) dut (
    .slave_clk(slave_clk), .rstn(rstn), .spi_clk(spi_clk), .cs_n(cs_n),
    .mosi(mosi), .miso(miso), .t_start(t_start), .d_in_s(d_in_s),
    .t_size_s(t_size_s), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .d_out_s(d_out_s), .busy(busy), .done(done), .err(err)
  );

  always #5 slave_clk = ~slave_clk;

  always @(negedge slave_clk) begin
    if (done) done_cnt++;
    if (err)  err_cnt++;
  end

  typedef struct {
    logic       use_ts;
    logic       cp, ch, lsb;
    logic [3:0] ts;
    logic [7:0] din, mo, exp_dout, exp_miso;
  } vec_t;

  vec_t vecs[7];

  function automatic int eff_size(input logic [3:0] ts);
    return (ts == 4'd0 || ts > 4'd8) ? 8 : int'(ts);
  endfunction

  function automatic logic [7:0] low_bits(input logic [7:0] v, input int n);
    return v & 8'((1 << n) - 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input logic cp, input logic ch, input logic lsb,
                             input logic [3:0] ts, input logic [7:0] din);
    @(negedge slave_clk);
    cpol = cp; cpha = ch; lsb_first = lsb; t_size_s = ts; d_in_s = din;
    t_start = 1'b1;
    @(negedge slave_clk);
    t_start = 1'b0;
  endtask

  // Bus master: n bits, aborting by raising cs_n after stop_after bits
  task automatic master_xfer(input logic cp, input logic ch, input logic lsb, input int n,
                             input logic [7:0] mo, input int stop_after, output logic [7:0] mi);
    int idx;
    mi = 8'h00;
    spi_clk = cp;
    mosi = 1'b0;
    repeat (6) @(negedge slave_clk);
    cs_n = 1'b0;
    if (!ch) mosi = mo[lsb ? 0 : n-1];
    repeat (8) @(negedge slave_clk);
    for (int k = 0; k < n; k++) begin
      if (k == stop_after) break;
      idx = lsb ? k : n-1-k;
      spi_clk = ~cp;
      if (ch) mosi = mo[idx];
      else    mi[idx] = miso;
      repeat (HALF) @(negedge slave_clk);
      spi_clk = cp;
      if (ch) mi[idx] = miso;
      else if (k+1 < n) mosi = mo[lsb ? k+1 : n-2-k];
      repeat (HALF) @(negedge slave_clk);
    end
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (10) @(negedge slave_clk);
  endtask

  task automatic run_xfer(input string tag, input logic use_ts, input logic cp, input logic ch,
                          input logic lsb, input logic [3:0] ts, input logic [7:0] din,
                          input logic [7:0] mo, input logic [7:0] exp_dout, input logic [7:0] exp_miso);
    int d0, e0;
    logic [7:0] mi;
    d0 = done_cnt;
    e0 = err_cnt;
    if (use_ts) begin
      m_cp = cp; m_ch = ch; m_lsb = lsb; m_n = eff_size(ts);
      pulse_start(cp, ch, lsb, ts, din);
    end
    master_xfer(m_cp, m_ch, m_lsb, m_n, mo, 99, mi);
    check({tag, "_dout"}, d_out_s, exp_dout);
    check({tag, "_miso_word"}, mi, exp_miso);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_err_pulses"}, err_cnt - e0, 0);
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_miso_idle"}, miso, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    logic [7:0] mi, din, mo, last_dout;
    logic [3:0] ts;
    logic [1:0] md;
    logic       lsb, use_ts;
    int         d0, e0, n;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd8,  8'h55, 8'hA3, 8'hA3, 8'h55};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd8,  8'hAA, 8'h0F, 8'h0F, 8'hAA};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd5,  8'h13, 8'h16, 8'h16, 8'h13};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  8'hC4, 8'h5A, 8'h5A, 8'hC4};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd12, 8'h81, 8'h7E, 8'h7E, 8'h81};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd2,  8'hFE, 8'h03, 8'h03, 8'h02};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  8'h00, 8'h02, 8'h02, 8'h00};

    repeat (3) @(negedge slave_clk);
    check("rst_dout", d_out_s, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_miso", miso, 1'b0);
    rstn = 1'b1;
    repeat (4) @(negedge slave_clk);
    check("idle_busy", busy, 1'b0);

    for (int i = 0; i < 7; i++)
      run_xfer($sformatf("vec%0d", i), vecs[i].use_ts, vecs[i].cp, vecs[i].ch, vecs[i].lsb,
               vecs[i].ts, vecs[i].din, vecs[i].mo, vecs[i].exp_dout, vecs[i].exp_miso);

    for (int i = 0; i < 20; i++) begin
      md     = 2'($urandom_range(0, 3));
      lsb    = 1'($urandom_range(0, 1));
      ts     = 4'($urandom_range(0, 15));
      din    = 8'($urandom_range(0, 255));
      mo     = 8'($urandom_range(0, 255));
      use_ts = ($urandom_range(0, 4) != 0);
      n      = use_ts ? eff_size(ts) : m_n;
      run_xfer($sformatf("rnd%0d", i), use_ts, md[1], md[0], lsb, ts, din, mo,
               low_bits(mo, n), use_ts ? low_bits(din, n) : 8'h00);
    end

    // t_start during a transfer is refused and leaves settings alone
    d0 = done_cnt; e0 = err_cnt;
    pulse_start(1'b0, 1'b0, 1'b0, 4'd8, 8'h96);
    m_cp = 1'b0; m_ch = 1'b0; m_lsb = 1'b0; m_n = 8;
    fork
      master_xfer(1'b0, 1'b0, 1'b0, 8, 8'h69, 99, mi);
      begin
        repeat (40) @(negedge slave_clk);
        pulse_start(1'b1, 1'b1, 1'b1, 4'd3, 8'hFF);
      end
    join
    check("busy_start_err", err_cnt - e0, 1);
    check("busy_start_done", done_cnt - d0, 1);
    check("busy_start_dout", d_out_s, 8'h69);
    check("busy_start_miso", mi, 8'h96);
    run_xfer("after_ignored", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'hB7, 8'hB7, 8'h00);

    // Abort after 3 bits
    last_dout = d_out_s;
    d0 = done_cnt; e0 = err_cnt;
    pulse_start(1'b0, 1'b0, 1'b0, 4'd8, 8'h3C);
    master_xfer(1'b0, 1'b0, 1'b0, 8, 8'hE1, 3, mi);
    check("abort_err", err_cnt - e0, 1);
    check("abort_done", done_cnt - d0, 0);
    check("abort_dout", d_out_s, last_dout);
    check("abort_busy", busy, 1'b0);
    check("abort_miso", miso, 1'b0);

    // Reset in the middle of a transfer
    d0 = done_cnt; e0 = err_cnt;
    pulse_start(1'b0, 1'b0, 1'b0, 4'd8, 8'hA5);
    fork
      master_xfer(1'b0, 1'b0, 1'b0, 8, 8'h3C, 4, mi);
      begin
        repeat (39) @(negedge slave_clk);
        rstn = 1'b0;
        #1;
        check("midrst_dout", d_out_s, 8'h00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_err", err, 1'b0);
        check("midrst_miso", miso, 1'b0);
      end
    join
    @(negedge slave_clk);
    rstn = 1'b1;
    m_cp = 1'b0; m_ch = 1'b0; m_lsb = 1'b0; m_n = 8;
    repeat (6) @(negedge slave_clk);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_no_err", err_cnt - e0, 0);
    run_xfer("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h5A, 8'hC3, 8'hC3, 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
